// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle ripple adder, CHUNK bits per clock.
// valid/ready on both sides; one add in flight at a time.
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] r;
  logic             c;
  logic             c_msb;

  always_comb begin
    base  = 32'(k_q) * 32'(CHUNK);
    a_sl  = CHUNK'(a_q >> base);
    b_sl  = CHUNK'(b_q >> base);
    {c, r} = {1'b0, a_sl} + {1'b0, b_sl}
           + (CHUNK+1)'(carry_q);
    // carry into the slice MSB recovered from its sum bit
    c_msb = r[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
    s_d   = (s_q & ~(SMASK << base))
          | (WIDTH'(r) << base);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q     <= s_d;
          carry_q <= c;
          k_q     <= k_q + KW'(1);
          if (k_q == KLAST) begin
            cout_q  <= c;
            ovf_q   <= c_msb ^ c;
            k_q     <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: three configs (8/2, 2/1, 2/2) checked every
// cycle against an arithmetic model of the add/handshake rules.
module tb_chunked_adder;

  localparam int NDUT = 3;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  function automatic int nc(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [NDUT];
  logic       out_ready [NDUT];
  logic       cin       [NDUT];
  logic [7:0] a         [NDUT];
  logic [7:0] b         [NDUT];
  logic       in_ready  [NDUT];
  logic       out_valid [NDUT];
  logic       busy      [NDUT];
  logic       cout      [NDUT];
  logic       ovf       [NDUT];
  logic [7:0] s_w       [NDUT];
  logic [7:0] s0;
  logic [1:0] s1;
  logic [1:0] s2;

  always_comb begin
    s_w[0] = s0;
    s_w[1] = {6'b0, s1};
    s_w[2] = {6'b0, s2};
  end

  chunked_adder #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .s(s0), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  chunked_adder #(.WIDTH(2), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][1:0]), .b(b[1][1:0]), .cin(cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .s(s1), .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  chunked_adder #(.WIDTH(2), .CHUNK(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][1:0]), .b(b[2][1:0]), .cin(cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .s(s2), .cout(cout[2]), .ovf(ovf[2]), .busy(busy[2])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int i,
                     input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h want %h at %0t",
               nm, i, got, exp, $time);
    end
  endtask

  // model state: one pending add per config plus the held result
  bit         pend [NDUT];
  int         acc  [NDUT];
  logic [7:0] es   [NDUT];
  logic       ec   [NDUT];
  logic       eo   [NDUT];
  logic [7:0] ls   [NDUT];
  logic       lc   [NDUT];
  logic       lo   [NDUT];

  always @(negedge clk) begin
    logic [7:0] m;
    bit ev;
    int sum;
    bit sa;
    bit sb;
    bit ss;
    for (int i = 0; i < NDUT; i++) begin
      m = 8'((1 << wid(i)) - 1);
      if (!rst_n) begin
        pend[i] = 1'b0;
        ls[i] = 8'h00;
        lc[i] = 1'b0;
        lo[i] = 1'b0;
        chk("rst_out_valid", i, 8'(out_valid[i]), 8'd0);
        chk("rst_busy", i, 8'(busy[i]), 8'd0);
        chk("rst_s", i, s_w[i], 8'd0);
        chk("rst_cout", i, 8'(cout[i]), 8'd0);
        chk("rst_ovf", i, 8'(ovf[i]), 8'd0);
      end else begin
        ev = pend[i] && (cyc >= acc[i] + 1 + nc(i));
        chk("out_valid", i, 8'(out_valid[i]), 8'(ev));
        chk("in_ready", i, 8'(in_ready[i]), 8'(!pend[i]));
        chk("busy", i, 8'(busy[i]), 8'(pend[i]));
        if (ev) begin
          chk("s", i, s_w[i] & m, es[i]);
          chk("cout", i, 8'(cout[i]), 8'(ec[i]));
          chk("ovf", i, 8'(ovf[i]), 8'(eo[i]));
        end else if (!pend[i]) begin
          chk("s_held", i, s_w[i] & m, ls[i]);
          chk("cout_held", i, 8'(cout[i]), 8'(lc[i]));
          chk("ovf_held", i, 8'(ovf[i]), 8'(lo[i]));
        end
        if (ev && out_ready[i]) begin
          pend[i] = 1'b0;
          ls[i] = es[i];
          lc[i] = ec[i];
          lo[i] = eo[i];
        end else if (!pend[i] && in_valid[i]) begin
          sum = int'(a[i] & m) + int'(b[i] & m) + int'(cin[i]);
          es[i] = 8'(sum) & m;
          ec[i] = ((sum >> wid(i)) & 1) != 0;
          sa = ((a[i] >> (wid(i) - 1)) & 8'd1) != 0;
          sb = ((b[i] >> (wid(i) - 1)) & 8'd1) != 0;
          ss = ((es[i] >> (wid(i) - 1)) & 8'd1) != 0;
          eo[i] = (sa == sb) && (ss != sa);
          pend[i] = 1'b1;
          acc[i] = cyc;
        end
      end
    end
  end

  task automatic do_op(input int i, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci,
                       input int stall, input bit rr, input bit lit,
                       input logic [7:0] xs, input logic xc,
                       input logic xo);
    int k;
    logic [7:0] m;
    m = 8'((1 << wid(i)) - 1);
    @(posedge clk); #1;
    a[i] = av;
    b[i] = bv;
    cin[i] = ci;
    in_valid[i] = 1'b1;
    out_ready[i] = 1'b0;
    k = 0;
    while (!in_ready[i] && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    a[i] = 8'($urandom);
    b[i] = 8'($urandom);
    cin[i] = 1'($urandom);
    out_ready[i] = rr ? 1'($urandom) : 1'b0;
    k = 0;
    while (!out_valid[i] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", i, 8'(k - 1), 8'(nc(i)));
    if (lit) begin
      chk("lit_s", i, s_w[i] & m, xs);
      chk("lit_cout", i, 8'(cout[i]), 8'(xc));
      chk("lit_ovf", i, 8'(ovf[i]), 8'(xo));
    end
    repeat (stall) begin
      @(posedge clk); #1;
      in_valid[i] = rr ? 1'b0 : 1'($urandom);
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
      out_ready[i] = 1'b0;
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
  endtask

  initial begin
    logic [4:0] v;
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      cin[i] = 1'b0;
      a[i] = 8'h00;
      b[i] = 8'h00;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_in_ready", 0, 8'(in_ready[0]), 8'd1);
    chk("lit_rst_out_valid", 0, 8'(out_valid[0]), 8'd0);
    chk("lit_rst_busy", 0, 8'(busy[0]), 8'd0);
    chk("lit_rst_s", 0, s_w[0], 8'h00);

    do_op(0, 8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op(0, 8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    do_op(0, 8'h80, 8'h80, 1'b1, 0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
    do_op(0, 8'h35, 8'h4A, 1'b1, 5, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);

    // abort an add in its second RUN cycle
    @(posedge clk); #1;
    a[0] = 8'h12;
    b[0] = 8'h34;
    cin[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_abort_s", 0, s_w[0], 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("lit_abort_no_valid", 0, 8'(out_valid[0]), 8'd0);
    end
    do_op(0, 8'h01, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);

    repeat (40) begin
      do_op(0, 8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom), 1'b0,
            8'h00, 1'b0, 1'b0);
    end

    for (int i = 1; i < NDUT; i++) begin
      for (int j = 0; j < 32; j++) begin
        v = 5'(j);
        do_op(i, {6'b0, v[1:0]}, {6'b0, v[3:2]}, v[4],
              int'($urandom_range(0, 3)), 1'($urandom), 1'b0,
              8'h00, 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised, multi-cycle ripple adder that computes a WIDTH-bit sum in CHUNK-bit slices, one slice per clock. It generalises the team's 2-bit combinational adder netlist in three ways:
- width is configurable;
- it adds carry-in and signed-overflow outputs;
- it wraps the datapath in valid/ready handshakes.

It sits between operand producers and result consumers wherever an area-lean adder is preferred over a single-cycle one.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- CHUNK, 2, bits added per cycle; must divide WIDTH. Define N = WIDTH/CHUNK (cycles per add).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  s, cout, ovf are valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum, equal to (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN or DONE.

## Operation
- Three-state FSM: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, latch a, b, cin into internal registers, set slice index k=0 and carry register = cin, go to RUN.
  - Input values outside the handshake are ignored.
- RUN:
  - in_ready=0.
  - Each cycle computes {c, r} = a[k*CHUNK +: CHUNK] + b[k*CHUNK +: CHUNK] + carry, writes r into sum register slice k, sets carry = c, increments k.
  - On the final slice (k == N-1): compute the carry into bit WIDTH-1 bit-wise within the slice, set ovf = carry_into_msb ^ c and cout = c, go to DONE.
- DONE:
  - out_valid=1; s, cout, ovf are stable.
  - On out_ready, go to IDLE and drop out_valid.
  - Results stay held until accepted, whatever the inputs do.
- Output registers s, cout, ovf keep their last values after the result handshake. Only a new accepted result changes them.
- No overlap: a new operand is accepted only in IDLE. The earliest next accept is the cycle after the out handshake. Throughput is one add per N+2 cycles at best.
- Arithmetic:
  - Slice adder width is CHUNK+1.
  - cin and all carries are 1 bit. No saturation; the sum wraps modulo 2^WIDTH.
- CHUNK == WIDTH (N=1) is legal: RUN lasts exactly one cycle.
- Internal s register is not updated in a partial view. Visible s updates slice-by-slice during RUN, but is only defined while out_valid=1.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, k=0, s=0, cout=0, ovf=0, out_valid=0, busy=0.
  - in_ready=1 once reset is released.
- Reset asserted mid-RUN or in DONE aborts the operation; the pending result is discarded and is never presented.
- Latency: input accepted at edge E0 → out_valid high after edge E0+N (N RUN cycles). It stays high until the edge where out_ready=1 is sampled.
- in_ready and out_valid are decoded from the registered state only. There is no combinational path from in_valid or out_ready to any output.
- out_ready asserted while out_valid=0 has no effect. in_valid in RUN/DONE has no effect and is not queued.

## Test plan
- Reset value check: hold rst_n low, then release → in_ready=1, out_valid=0, busy=0, s=0x00, cout=0, ovf=0.
- WIDTH=8, CHUNK=2: a=0xFF, b=0x01, cin=0 → out_valid exactly 4 cycles after accept; s=0x00, cout=1, ovf=0.
- WIDTH=8, CHUNK=2, signed overflow: a=0x7F, b=0x01, cin=0 → s=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=1 → s=0x01, cout=1, ovf=1.
- Backpressure: a=0x35, b=0x4A, cin=1 with out_ready low for 5 cycles.
  - s=0x80 is held with out_valid=1 and in_ready=0 throughout, even while a/b toggle.
  - out_ready high → IDLE next cycle.
- Mid-operation reset: accept a=0x12, b=0x34, pulse rst_n low in RUN cycle 2, then release.
  - No out_valid is ever seen for that operation; outputs return to reset values.
  - The next add, 0x01+0x01, gives s=0x02.
- Exhaustive small config: WIDTH=2, CHUNK=1 (N=2) and WIDTH=2, CHUNK=2 (N=1). Sweep all 32 (a, b, cin) combinations with random out_ready stalls → s, cout, ovf match the reference model every time, with latency N.
